// File: rtl/jtcop_dec_pkg.sv
// Target codes for the BAC06 select table and the selector-state helper.
package jtcop_dec_pkg;

  localparam logic [3:0] TGT_NONE   = 4'd0;
  localparam int         TGT_MODE   = 1;
  localparam int         TGT_SFT    = 2;
  localparam int         TGT_MAP    = 3;
  localparam int         TGT_STRIDE = 3;

  function automatic int states(input int msw);
    return 1 << msw;
  endfunction

  // Code 0 is reserved for "no select", so chip k occupies codes 1+3k..3+3k
  function automatic logic [3:0] tgt_code(input int chip, input int off);
    return 4'(TGT_STRIDE * chip + off);
  endfunction

endpackage

// File: rtl/jtcop_edge.sv
// Level-change detector; qualify chg with din for rising, with ~din for falling.
module jtcop_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic chg
);

  logic din_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_l <= 1'b0;
    else        din_l <= din;
  end

  assign chg = din ^ din_l;

endmodule

// File: rtl/jtcop_mapsel_dec.sv
// BAC06 chip-select decoder with rotating map selector and VBL strobes.
// Optional selector readback port enabled by JTCOP_MAPSEL_RD_EN.
module jtcop_mapsel_dec
  import jtcop_dec_pkg::*;
#(
  parameter int                           N_CHIPS   = 3,
  parameter int                           MSW       = 2,
  parameter logic [7:0]                   BASE      = 8'h24,
  parameter logic [2:0]                   UP_SLOT   = 3'd2,
  parameter logic [2:0]                   CLR_SLOT  = 3'd5,
  parameter logic [32*states(MSW)-1:0]    MAP_TABLE = 128'h032A_1987_0000_0654_F019_0000_8765_4321
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [23:1]            A,
  input  logic                   ASn,
  input  logic                   RnW,
  input  logic                   LVBL,
  output logic [3*N_CHIPS-1:0]   chip_cs,
  output logic                   disp_cs,
  output logic [MSW-1:0]         mapsel,
  output logic                   vint_clr,
  output logic                   obj_copy
`ifdef JTCOP_MAPSEL_RD_EN
  ,
  output logic [15:0]            rd_data
`endif
);

  logic       hit, up_cs, clr_cs, dec_en;
  logic [2:0] slot;
  logic [3:0] code;
  logic       up_chg, clr_chg, vbl_chg;
  logic       up_rise, clr_rise;
  logic       armed;
  logic       unused_a;

  assign hit    = !ASn && (A[23:16] == BASE);
  assign slot   = A[15:13];
  assign up_cs  = hit && (slot == UP_SLOT) && RnW;
  assign clr_cs = hit && (slot == CLR_SLOT) && !RnW;
  assign dec_en = hit && (slot != UP_SLOT) && (slot != CLR_SLOT);
  assign code   = MAP_TABLE[{slot, mapsel, 2'b00} +: 4];

  assign unused_a = ^A[12:1];

  always_comb begin
    chip_cs = '0;
    disp_cs = 1'b0;
    for (int k = 0; k < N_CHIPS; k++) begin
      chip_cs[3*k]   = dec_en && (code != TGT_NONE) && (code == tgt_code(k, TGT_MODE));
      chip_cs[3*k+1] = dec_en && (code != TGT_NONE) && (code == tgt_code(k, TGT_SFT));
      chip_cs[3*k+2] = dec_en && (code != TGT_NONE) && (code == tgt_code(k, TGT_MAP));
    end
    for (int k = 0; k < N_CHIPS; k++)
      disp_cs = disp_cs | chip_cs[3*k+1] | chip_cs[3*k+2];
  end

  jtcop_edge u_up  (.clk(clk), .rst_n(rst_n), .din(up_cs),  .chg(up_chg));
  jtcop_edge u_clr (.clk(clk), .rst_n(rst_n), .din(clr_cs), .chg(clr_chg));
  jtcop_edge u_vbl (.clk(clk), .rst_n(rst_n), .din(LVBL),   .chg(vbl_chg));

  assign up_rise  = up_cs  & up_chg;
  assign clr_rise = clr_cs & clr_chg;

  // Counting on the select edge means a held strobe advances only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mapsel <= '0;
    else if (clr_rise) mapsel <= '0;
    else if (up_rise)  mapsel <= mapsel + MSW'(1);
  end

  // armed masks the spurious edge seen against the reset value of the LVBL history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      vint_clr <= 1'b0;
      obj_copy <= 1'b0;
    end else begin
      armed    <= 1'b1;
      vint_clr <= armed & vbl_chg & LVBL;
      obj_copy <= armed & vbl_chg & ~LVBL;
    end
  end

`ifdef JTCOP_MAPSEL_RD_EN
  assign rd_data = (hit && RnW && (slot == CLR_SLOT || slot == UP_SLOT)) ? 16'(mapsel) : 16'h0000;
`endif

endmodule

// File: tb/tb_jtcop_mapsel_dec.sv
// Directed bench for jtcop_mapsel_dec with an expectation queue.
module tb_jtcop_mapsel_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:1] abus;
  logic        asn, rnw, lvbl;
  logic [8:0]  chip_cs;
  logic        disp_cs;
  logic [1:0]  mapsel;
  logic        vint_clr, obj_copy;
  logic [13:0] obs;
`ifdef JTCOP_MAPSEL_RD_EN
  logic [15:0] rd_data;
`endif

  jtcop_mapsel_dec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (abus),
    .ASn      (asn),
    .RnW      (rnw),
    .LVBL     (lvbl),
    .chip_cs  (chip_cs),
    .disp_cs  (disp_cs),
    .mapsel   (mapsel),
    .vint_clr (vint_clr),
    .obj_copy (obj_copy)
`ifdef JTCOP_MAPSEL_RD_EN
    ,
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {chip_cs, disp_cs, mapsel, vint_clr, obj_copy};

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [1:0] ms;

  // slot x mapsel -> target code (1..9 = chip_cs bit+1, others select nothing)
  int tbl [8][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{0, 0, 0, 0}, '{9, 1, 0, 15},
                     '{4, 5, 6, 0}, '{0, 0, 0, 0}, '{7, 8, 9, 1}, '{10, 2, 3, 0}};

  function automatic logic [13:0] mk(input logic [8:0] cs, input logic [1:0] m,
                                     input logic vi, input logic ob);
    return {cs, |(cs & 9'b110_110_110), m, vi, ob};
  endfunction

  function automatic logic [8:0] dec(input logic [23:0] a, input logic n, input logic [1:0] m);
    logic [8:0] cs;
    logic [2:0] s;
    int         code;
    cs = '0;
    if (!n && a[23:16] == 8'h24) begin
      s = a[15:13];
      if (s != 3'd2 && s != 3'd5) begin
        code = tbl[s][m];
        if (code >= 1 && code <= 9) cs = 9'b1 << (code - 1);
      end
    end
    return cs;
  endfunction

  task automatic step(input string tag, input logic [13:0] v);
    exp_t e;
    sb.push_back('{tag, v});
    #2;
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input string tag, input logic [23:0] a, input logic r);
    abus = a[23:1];
    asn  = 1'b0;
    rnw  = r;
    step(tag, mk(dec(a, 1'b0, ms), ms, 1'b0, 1'b0));
  endtask

  task automatic idle(input string tag);
    asn = 1'b1;
    rnw = 1'b1;
    step(tag, mk(9'h0, ms, 1'b0, 1'b0));
  endtask

  task automatic up(input string tag);
    acc(tag, 24'h244000, 1'b1);
    ms = ms + 2'd1;
    idle(tag);
  endtask

`ifdef JTCOP_MAPSEL_RD_EN
  task automatic rd_chk(input string tag, input logic [15:0] v);
    checks++;
    assert (rd_data === v) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, rd_data, v);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    abus  = '0;
    asn   = 1'b1;
    rnw   = 1'b1;
    lvbl  = 1'b1;
    ms    = 2'd0;
    @(posedge clk);
    #1;
    step("reset", 14'h0);
    step("reset_hold", 14'h0);
    rst_n = 1'b1;
    idle("release0");
    idle("release1");

    // mode select of the first chip at mapsel 0
    abus = 23'h120000;
    asn  = 1'b0;
    step("bmode", mk(9'b000_000_001, 2'd0, 1'b0, 1'b0));
    idle("bmode_end");

    for (int i = 0; i < 4; i++) up("up_step");

    // one long access counts once
    abus = 23'h122000;
    asn  = 1'b0;
    step("long_first", mk(9'h0, ms, 1'b0, 1'b0));
    ms = ms + 2'd1;
    for (int i = 0; i < 19; i++) step("long_hold", mk(9'h0, ms, 1'b0, 1'b0));
    idle("long_end");

    up("to3");
    up("to3");
    abus = 23'h125000;
    asn  = 1'b0;
    rnw  = 1'b0;
    step("clr_write", mk(9'h0, 2'd3, 1'b0, 1'b0));
    ms = 2'd0;
    idle("clr_done");

    up("to1");
    abus = 23'h125000;
    asn  = 1'b0;
    rnw  = 1'b1;
`ifdef JTCOP_MAPSEL_RD_EN
    #1;
    rd_chk("rd_clr_slot", 16'h0001);
`endif
    step("clr_read", mk(9'h0, 2'd1, 1'b0, 1'b0));
    idle("clr_read_keep");
    abus = 23'h125000;
    asn  = 1'b0;
    rnw  = 1'b0;
    step("clr_write2", mk(9'h0, 2'd1, 1'b0, 1'b0));
    ms = 2'd0;
    idle("clr_done2");

    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s < 8; s++) begin
        if (s != 2) begin
          acc("sweep", {8'h24, 3'(s), 13'h0}, 1'b1);
          idle("sweep_gap");
        end
      end
      if (m == 2) begin
        abus = 23'h120000;
        asn  = 1'b0;
        step("bmap_only", mk(9'b000_000_100, 2'd2, 1'b0, 1'b0));
        acc("base25", 24'h250000, 1'b1);
        abus = 23'h120000;
        asn  = 1'b1;
        step("asn_high", mk(9'h0, 2'd2, 1'b0, 1'b0));
      end
      up("sweep_up");
    end

    // vblank strobes
    lvbl = 1'b0;
    step("lvbl_fall", mk(9'h0, ms, 1'b0, 1'b0));
    step("obj_copy", mk(9'h0, ms, 1'b0, 1'b1));
    step("obj_end", mk(9'h0, ms, 1'b0, 1'b0));
    lvbl = 1'b1;
    step("lvbl_rise", mk(9'h0, ms, 1'b0, 1'b0));
    step("vint_clr", mk(9'h0, ms, 1'b1, 1'b0));
    step("vint_end", mk(9'h0, ms, 1'b0, 1'b0));

    // reset in the middle of a held up access
    up("pre_rst");
    lvbl = 1'b0;
    step("f0", mk(9'h0, ms, 1'b0, 1'b0));
    step("f1", mk(9'h0, ms, 1'b0, 1'b1));
    abus = 23'h122000;
    asn  = 1'b0;
    rnw  = 1'b1;
    step("held_first", mk(9'h0, 2'd1, 1'b0, 1'b0));
    step("held_next", mk(9'h0, 2'd2, 1'b0, 1'b0));
    rst_n = 1'b0;
    lvbl  = 1'b1;
    step("async_rst", mk(9'h0, 2'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    step("rel_a", mk(9'h0, 2'd0, 1'b0, 1'b0));
    step("rel_b", mk(9'h0, 2'd1, 1'b0, 1'b0));
    step("rel_c", mk(9'h0, 2'd1, 1'b0, 1'b0));
    ms = 2'd1;
    idle("rel_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
